tug_light_bar: RTL and testbench
================================

// Module: tug_light_bar
// PURPOSE
//  Parametrised tug-of-war playfield: a row of NUM_LIGHTS lights with exactly one lit at any time.
//  The lit position moves one step per player press, toward the pressing player's side.
//  Detects when the light is pulled off either end, then freezes until the next round.
//  Replaces the per-light cell chain with one block; feeds the LED driver and the round/score logic.
// PARAMETERS
//  NUM_LIGHTS  9               number of lights; odd, >= 3
//  CENTER      NUM_LIGHTS/2    index lit after reset/resetRound
//  POS_W       $clog2(NUM_LIGHTS)  width of internal position register
//  SCORE_W     3               score counter width (used only with TUG_SCORE_EN)
// PORTS
//  clk         in   1           system clock
//  reset       in   1           synchronous, active-high; full reset incl. scores
//  resetRound  in   1           synchronous, active-high; new round, scores kept
//  L           in   1           left player press, one-cycle pulse (conditioned upstream)
//  R           in   1           right player press, one-cycle pulse (conditioned upstream)
//  lights      out  NUM_LIGHTS  one-hot; bit NUM_LIGHTS-1 = leftmost, bit 0 = rightmost
//  leftWin     out  1           high while in state WIN_L
//  rightWin    out  1           high while in state WIN_R
//  roundDone   out  1           one-cycle pulse on entry to WIN_L or WIN_R
//  leftScore   out  SCORE_W     left rounds won (0 without TUG_SCORE_EN)
//  rightScore  out  SCORE_W     right rounds won (0 without TUG_SCORE_EN)
// BEHAVIOUR
//  - One clock; all state updates on posedge clk; reset synchronous active-high.
//  - State: pos (POS_W bits), FSM {PLAY, WIN_L, WIN_R}; all outputs registered or decoded from registers.
//  - reset: pos=CENTER, FSM=PLAY, leftWin=rightWin=roundDone=0, scores=0.
//  - resetRound: as reset, but scores hold. reset and resetRound override all other inputs.
//  - lights = 1 << pos in every state; stays at the edge position after a win.
//  - PLAY, move = L & ~R:
//    - pos < NUM_LIGHTS-1: pos+1.
//    - pos == NUM_LIGHTS-1: -> WIN_L, pos holds, roundDone=1 next cycle.
//  - PLAY, move = R & ~L:
//    - pos > 0: pos-1.
//    - pos == 0: -> WIN_R, pos holds, roundDone=1 next cycle.
//  - PLAY, L&R together or neither: no change (a tie cancels).
//  - WIN_L / WIN_R: L, R ignored. Hold until reset or resetRound; no self-exit.
//  - Latency: a press in cycle n is visible on lights/leftWin/rightWin after posedge n+1.
//  - roundDone: exactly one cycle per win. Never asserted in the cycle of reset/resetRound.
//  - pos never leaves [0, NUM_LIGHTS-1]; lights is never all-zero or multi-hot.
// CONFIGURATION
//  - TUG_SCORE_EN defined: leftScore/rightScore increment by 1 on entry to WIN_L/WIN_R (same edge as roundDone).
//    Scores saturate at 2**SCORE_W-1. They are cleared only by reset, not by resetRound.
//  - TUG_SCORE_EN undefined: no counters are synthesised; leftScore/rightScore tied to 0.
// TESTING
//  1. reset=1 one cycle -> lights=9'b000010000, leftWin=rightWin=roundDone=0, scores=0.
//  2. Four L pulses -> lights 000100000, 001000000, 010000000, 100000000; fifth L ->
//     leftWin=1, roundDone=1 for one cycle, lights stays 100000000, leftScore=1 (with TUG_SCORE_EN).
//  3. In WIN_L, apply 3 R pulses -> lights and leftWin unchanged.
//     resetRound -> lights=000010000, leftWin=0, leftScore still 1.
//  4. L=R=1 for 5 cycles from center -> lights stays 000010000, no win.
//     Then R x5 -> rightWin=1, lights=000000001.
//  5. reset asserted the same cycle as a winning L at pos 8 -> PLAY, lights=000010000,
//     roundDone=0, scores=0.
//  6. TUG_SCORE_EN, SCORE_W=3: 9 left wins (resetRound between them) -> leftScore saturates at 7.
//     Without the macro, leftScore=rightScore=0 throughout.

Source files
------------

// File: rtl/tug_light_bar.sv
// tug_light_bar: tug-of-war playfield, one lit light pulled left/right by player presses
//   Ports: clk, reset (sync, full incl. scores), resetRound (sync, scores kept),
//          L/R (one-cycle presses), lights (one-hot, MSB = leftmost),
//          leftWin/rightWin (win state), roundDone (one-cycle win pulse),
//          leftScore/rightScore (rounds won; counters only with TUG_SCORE_EN, else 0).
//   Optional feature macro: TUG_SCORE_EN
module tug_light_bar #(
    parameter int NUM_LIGHTS = 9,
    parameter int CENTER     = NUM_LIGHTS / 2,
    parameter int POS_W      = $clog2(NUM_LIGHTS),
    parameter int SCORE_W    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  resetRound,
    input  logic                  L,
    input  logic                  R,
    output logic [NUM_LIGHTS-1:0] lights,
    output logic                  leftWin,
    output logic                  rightWin,
    output logic                  roundDone,
    output logic [SCORE_W-1:0]    leftScore,
    output logic [SCORE_W-1:0]    rightScore
);
    typedef enum logic [1:0] {PLAY, WIN_L, WIN_R} state_t;
    state_t           r_state, w_next;
    logic [POS_W-1:0] r_pos, w_pos_next;
    logic             r_done;
    logic             w_clear, w_move_l, w_move_r, w_win_l, w_win_r;
    assign w_clear  = reset | resetRound;
    assign w_move_l = L & ~R;
    assign w_move_r = R & ~L;
    // a press at the far edge ends the round instead of moving the light
    assign w_win_l  = (r_state == PLAY) && w_move_l && (r_pos == POS_W'(NUM_LIGHTS - 1));
    assign w_win_r  = (r_state == PLAY) && w_move_r && (r_pos == '0);
    always_ff @(posedge clk) begin
        if (w_clear) begin
            r_state <= PLAY;
            r_pos   <= POS_W'(CENTER);
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_pos   <= w_pos_next;
            r_done  <= w_win_l | w_win_r;
        end
    end
    always_comb begin
        w_next     = w_win_l ? WIN_L : w_win_r ? WIN_R : r_state;
        w_pos_next = r_pos;
        if (r_state == PLAY && !w_win_l && !w_win_r)
            w_pos_next = w_move_l ? r_pos + 1'b1 : w_move_r ? r_pos - 1'b1 : r_pos;
    end
    always_comb begin
        lights    = NUM_LIGHTS'(1) << r_pos;
        leftWin   = (r_state == WIN_L);
        rightWin  = (r_state == WIN_R);
        roundDone = r_done;
    end
`ifdef TUG_SCORE_EN
    logic [SCORE_W-1:0] r_lscore, r_rscore;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lscore <= '0;
            r_rscore <= '0;
        end else if (!resetRound) begin
            if (w_win_l && r_lscore != '1) r_lscore <= r_lscore + 1'b1;
            if (w_win_r && r_rscore != '1) r_rscore <= r_rscore + 1'b1;
        end
    end
    assign leftScore  = r_lscore;
    assign rightScore = r_rscore;
`else
    assign leftScore  = '0;
    assign rightScore = '0;
`endif
endmodule

// File: tb/tb_tug_light_bar.sv
// tb_tug_light_bar: scoreboard bench for tug_light_bar with directed vectors
module tb_tug_light_bar;
`ifdef TUG_SCORE_EN
    localparam bit SCORE_ON = 1'b1;
`else
    localparam bit SCORE_ON = 1'b0;
`endif
    typedef struct packed {
        logic [8:0] lights;
        logic       lw;
        logic       rw;
        logic       rd;
        logic [2:0] ls;
        logic [2:0] rs;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0, resetRound = 1'b0, L = 1'b0, R = 1'b0;
    logic [8:0] lights;
    logic       leftWin, rightWin, roundDone;
    logic [2:0] leftScore, rightScore;
    int         checks = 0, errors = 0;
    exp_t       q[$];
    string      nq[$];

    tug_light_bar #(.NUM_LIGHTS(9), .SCORE_W(3)) dut (
        .clk(clk), .reset(reset), .resetRound(resetRound), .L(L), .R(R),
        .lights(lights), .leftWin(leftWin), .rightWin(rightWin), .roundDone(roundDone),
        .leftScore(leftScore), .rightScore(rightScore)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] es(input int v);
        return SCORE_ON ? 3'(v) : 3'd0;
    endfunction

    task automatic step(input string name, input logic rst, input logic rr, input logic l, input logic r,
                        input logic [8:0] el, input logic elw, input logic erw, input logic erd,
                        input int els, input int ers);
        exp_t e;
        @(negedge clk);
        reset = rst; resetRound = rr; L = l; R = r;
        e = '{lights: el, lw: elw, rw: erw, rd: erd, ls: es(els), rs: es(ers)};
        q.push_back(e);
        nq.push_back(name);
        @(posedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t  e;
            exp_t  a;
            string n;
            e = q.pop_front();
            n = nq.pop_front();
            a = '{lights: lights, lw: leftWin, rw: rightWin, rd: roundDone, ls: leftScore, rs: rightScore};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got lights=%b lw=%b rw=%b rd=%b ls=%0d rs=%0d, want lights=%b lw=%b rw=%b rd=%b ls=%0d rs=%0d",
                         n, a.lights, a.lw, a.rw, a.rd, a.ls, a.rs, e.lights, e.lw, e.rw, e.rd, e.ls, e.rs);
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        step("reset", 1, 0, 0, 0, 9'b000010000, 0, 0, 0, 0, 0);
        step("l1", 0, 0, 1, 0, 9'b000100000, 0, 0, 0, 0, 0);
        step("l2", 0, 0, 1, 0, 9'b001000000, 0, 0, 0, 0, 0);
        step("l3", 0, 0, 1, 0, 9'b010000000, 0, 0, 0, 0, 0);
        step("l4", 0, 0, 1, 0, 9'b100000000, 0, 0, 0, 0, 0);
        step("l5_win", 0, 0, 1, 0, 9'b100000000, 1, 0, 1, 1, 0);
        step("winl_idle", 0, 0, 0, 0, 9'b100000000, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++)
            step("winl_r_ignored", 0, 0, 0, 1, 9'b100000000, 1, 0, 0, 1, 0);
        step("winl_l_ignored", 0, 0, 1, 0, 9'b100000000, 1, 0, 0, 1, 0);
        step("round_reset", 0, 1, 0, 0, 9'b000010000, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++)
            step("tie", 0, 0, 1, 1, 9'b000010000, 0, 0, 0, 1, 0);
        step("r1", 0, 0, 0, 1, 9'b000001000, 0, 0, 0, 1, 0);
        step("r2", 0, 0, 0, 1, 9'b000000100, 0, 0, 0, 1, 0);
        step("r3", 0, 0, 0, 1, 9'b000000010, 0, 0, 0, 1, 0);
        step("r4", 0, 0, 0, 1, 9'b000000001, 0, 0, 0, 1, 0);
        step("r5_win", 0, 0, 0, 1, 9'b000000001, 0, 1, 1, 1, 1);
        step("winr_idle", 0, 0, 0, 0, 9'b000000001, 0, 1, 0, 1, 1);
        step("winr_l_ignored", 0, 0, 1, 0, 9'b000000001, 0, 1, 0, 1, 1);
        step("round_reset2", 0, 1, 1, 0, 9'b000010000, 0, 0, 0, 1, 1);
        step("l1b", 0, 0, 1, 0, 9'b000100000, 0, 0, 0, 1, 1);
        step("l2b", 0, 0, 1, 0, 9'b001000000, 0, 0, 0, 1, 1);
        step("l3b", 0, 0, 1, 0, 9'b010000000, 0, 0, 0, 1, 1);
        step("l4b", 0, 0, 1, 0, 9'b100000000, 0, 0, 0, 1, 1);
        step("reset_vs_win", 1, 0, 1, 0, 9'b000010000, 0, 0, 0, 0, 0);
        step("after_reset", 0, 0, 0, 0, 9'b000010000, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            logic [8:0] pat;
            for (int j = 1; j <= 4; j++) begin
                pat = 9'b000010000 << j;
                step("sat_move", 0, 0, 1, 0, pat, 0, 0, 0, k - 1 > 7 ? 7 : k - 1, 0);
            end
            step("sat_win", 0, 0, 1, 0, 9'b100000000, 1, 0, 1, k > 7 ? 7 : k, 0);
            step("sat_rr", 0, 1, 0, 0, 9'b000010000, 0, 0, 0, k > 7 ? 7 : k, 0);
        end
        step("final_reset", 1, 0, 0, 0, 9'b000010000, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
